matrix_seq_ctrl: RTL and testbench

MATRIX_SEQ_CTRL -- requirements
Module: matrix_seq_ctrl

---
 rtl/matrix_seq_pkg.sv | 43 ++++
 rtl/matrix_seq_tx_pacer.sv | 31 +++
 rtl/matrix_seq_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_matrix_seq_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_seq_pkg.sv
// Shared types and width helpers for the matrix sequencing controller.
package matrix_seq_pkg;

  // Controller states; the encoding is visible on the state port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_DIM  = 3'd1,
    ST_RX_A    = 3'd2,
    ST_RX_B    = 3'd3,
    ST_COMPUTE = 3'd4,
    ST_TX_RES  = 3'd5,
    ST_TX_ERR  = 3'd6
  } seq_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] ERR_BYTE_DEF  = 8'hEE;

  // clog2 with a floor of one bit, so single-value fields still have a port.
  function automatic int unsigned min1_clog2(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // Width able to hold N in 0..max_dim.
  function automatic int unsigned dim_w(input int unsigned max_dim);
    return $clog2(max_dim + 1);
  endfunction

  // Row-major element address width.
  function automatic int unsigned addr_w(input int unsigned max_dim);
    return min1_clog2(max_dim * max_dim);
  endfunction

  // Byte-within-element selector width.
  function automatic int unsigned rbyte_w(input int unsigned res_bytes);
    return min1_clog2(res_bytes);
  endfunction

  // Counter width covering every element/byte count without wrap.
  function automatic int unsigned cnt_w(input int unsigned max_dim, input int unsigned res_bytes);
    return $clog2(max_dim * max_dim * res_bytes + 1);
  endfunction

endpackage

// File: rtl/matrix_seq_tx_pacer.sv
// Issues one tx_start per request and refuses to issue again until the UART
// has acknowledged the byte by raising tx_busy.
module matrix_seq_tx_pacer (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic tx_busy,
  output logic tx_start,
  output logic guard
);

  logic issue_c;

  assign issue_c = req && !tx_busy && !guard;

  // Pulse register and guard: set on issue, cleared once the UART shows busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start <= 1'b0;
      guard    <= 1'b0;
    end else begin
      tx_start <= issue_c;
      if (issue_c) begin
        guard <= 1'b1;
      end else if (tx_busy) begin
        guard <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/matrix_seq_ctrl.sv
// Frame sequencer: receives SYNC, N, A[N*N], B[N*N] over UART, starts the
// multiplier, then streams the result out byte by byte (or one error byte).
// Optional receive/compute watchdog: define MATRIX_SEQ_TIMEOUT_EN.
module matrix_seq_ctrl
  import matrix_seq_pkg::*;
#(
  parameter int unsigned MAX_DIM     = 8,
  parameter int unsigned RES_BYTES   = 2,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter logic [7:0]  ERR_BYTE    = ERR_BYTE_DEF
`ifdef MATRIX_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 100000
`endif
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rx_valid,
  input  logic [7:0]                         rx_data,
  input  logic                               tx_busy,
  output logic                               tx_start,
  output logic                               tx_err,
  output logic                               mult_start,
  input  logic                               mult_done,
  output logic [dim_w(MAX_DIM)-1:0]          mult_dim,
  output logic                               we_a,
  output logic                               we_b,
  output logic [addr_w(MAX_DIM)-1:0]         wr_addr,
  output logic [addr_w(MAX_DIM)-1:0]         res_addr,
  output logic [rbyte_w(RES_BYTES)-1:0]      res_byte,
  output logic [2:0]                         state,
  output logic                               busy,
  output logic                               err
);

  localparam int unsigned DIM_W = dim_w(MAX_DIM);
  localparam int unsigned AW    = addr_w(MAX_DIM);
  localparam int unsigned RBW   = rbyte_w(RES_BYTES);
  localparam int unsigned CW    = cnt_w(MAX_DIM, RES_BYTES);
  localparam logic [DIM_W-1:0] MAX_N = DIM_W'(MAX_DIM);

  seq_state_e       state_q, state_d;
  logic [DIM_W-1:0] n_q, n_d, dim_c;
  logic [CW-1:0]    cnt_q, cnt_d, nn_c, total_c;
  logic [AW-1:0]    res_addr_q, res_addr_d;
  logic [RBW-1:0]   res_byte_q, res_byte_d;
  logic             err_q, err_d;
  logic             busy_q, mult_start_q, tx_err_q;
  logic             pace_req_c, guard, dim_bad_c, last_elem_c;

  // The error byte value is muxed in by the transmit datapath on tx_err.
  logic unused_err_byte;
  assign unused_err_byte = ^ERR_BYTE;

  assign dim_c       = DIM_W'(rx_data);
  assign dim_bad_c   = (dim_c == '0) || (dim_c > MAX_N) || ((rx_data >> DIM_W) != 8'd0);
  assign nn_c        = CW'(n_q) * CW'(n_q);
  assign total_c     = nn_c * CW'(RES_BYTES);
  assign last_elem_c = (cnt_q == nn_c - CW'(1));

`ifdef MATRIX_SEQ_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT_CYC + 1);
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           to_watch_c;

  // Watchdog counter, reloaded on every received byte and state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  // Shared tx_start/guard handshake for both result and error transmission.
  matrix_seq_tx_pacer u_pacer (
    .clk      (clk),
    .rst      (rst),
    .req      (pace_req_c),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .guard    (guard)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, datapath next values and the combinational write strobes.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    res_addr_d = res_addr_q;
    res_byte_d = res_byte_q;
    we_a       = 1'b0;
    we_b       = 1'b0;
    wr_addr    = AW'(cnt_q);
    pace_req_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = ST_RX_DIM;
          err_d   = 1'b0;
        end
      end
      ST_RX_DIM: begin
        if (rx_valid) begin
          n_d   = dim_c;
          cnt_d = '0;
          if (dim_bad_c) begin
            state_d = ST_TX_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_RX_A;
          end
        end
      end
      ST_RX_A: begin
        if (rx_valid) begin
          we_a = 1'b1;
          if (last_elem_c) begin
            cnt_d   = '0;
            state_d = ST_RX_B;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_RX_B: begin
        if (rx_valid) begin
          we_b = 1'b1;
          if (last_elem_c) begin
            cnt_d   = '0;
            state_d = ST_COMPUTE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_COMPUTE: begin
        if (mult_done) begin
          state_d    = ST_TX_RES;
          cnt_d      = '0;
          res_addr_d = '0;
          res_byte_d = '0;
        end
      end
      ST_TX_RES: begin
        // res_addr/res_byte describe the byte on the current tx_start pulse.
        pace_req_c = (cnt_q != total_c);
        if (tx_start) begin
          cnt_d = cnt_q + CW'(1);
          if (res_byte_q == RBW'(RES_BYTES - 1)) begin
            res_byte_d = '0;
            res_addr_d = res_addr_q + AW'(1);
          end else begin
            res_byte_d = res_byte_q + RBW'(1);
          end
        end
        if ((cnt_q == total_c) && !tx_busy && !guard) begin
          state_d = ST_IDLE;
        end
      end
      ST_TX_ERR: begin
        pace_req_c = (cnt_q == '0);
        if (tx_start) begin
          cnt_d = cnt_q + CW'(1);
        end
        if ((cnt_q != '0) && !tx_busy && !guard) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef MATRIX_SEQ_TIMEOUT_EN
    to_watch_c = (state_q inside {ST_RX_A, ST_RX_B, ST_COMPUTE});
    if (to_watch_c && !rx_valid && (state_d == state_q) &&
        (to_cnt_q == TOW'(TIMEOUT_CYC - 1))) begin
      state_d = ST_TX_ERR;
      err_d   = 1'b1;
      cnt_d   = '0;
    end
    to_cnt_d = (!to_watch_c || rx_valid || (state_d != state_q)) ? '0 : to_cnt_q + TOW'(1);
`endif
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q          <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      res_addr_q   <= '0;
      res_byte_q   <= '0;
      busy_q       <= 1'b0;
      mult_start_q <= 1'b0;
      tx_err_q     <= 1'b0;
    end else begin
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      res_addr_q   <= res_addr_d;
      res_byte_q   <= res_byte_d;
      busy_q       <= (state_d != ST_IDLE);
      mult_start_q <= (state_q == ST_RX_B) && (state_d == ST_COMPUTE);
      tx_err_q     <= (state_d == ST_TX_ERR);
    end
  end

  assign state      = state_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign mult_dim   = n_q;
  assign mult_start = mult_start_q;
  assign tx_err     = tx_err_q;
  assign res_addr   = res_addr_q;
  assign res_byte   = res_byte_q;

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Directed bench for matrix_seq_ctrl with a small UART busy model.
// Defining MATRIX_SEQ_TIMEOUT_EN also builds and exercises the watchdog.
module tb_matrix_seq_ctrl;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RX_DIM  = 3'd1;
  localparam logic [2:0] S_RX_A    = 3'd2;
  localparam logic [2:0] S_RX_B    = 3'd3;
  localparam logic [2:0] S_COMPUTE = 3'd4;
  localparam logic [2:0] S_TX_ERR  = 3'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       tx_busy;
  logic       tx_start, tx_err, mult_start;
  logic       mult_done = 1'b0;
  logic [3:0] mult_dim;
  logic       we_a, we_b;
  logic [5:0] wr_addr, res_addr;
  logic [0:0] res_byte;
  logic [2:0] state;
  logic       busy, err;

  matrix_seq_ctrl #(
    .MAX_DIM     (8),
    .RES_BYTES   (2),
    .SYNC_BYTE   (8'hA5),
    .ERR_BYTE    (8'hEE)
`ifdef MATRIX_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (50)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_err     (tx_err),
    .mult_start (mult_start),
    .mult_done  (mult_done),
    .mult_dim   (mult_dim),
    .we_a       (we_a),
    .we_b       (we_b),
    .wr_addr    (wr_addr),
    .res_addr   (res_addr),
    .res_byte   (res_byte),
    .state      (state),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // UART model: busy for busy_len cycles after each observed tx_start.
  int busy_len = 1;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Event logger sampling DUT outputs at the clock edge.
  logic       clr_log = 1'b0;
  int         cyc = 0;
  int         tx_n = 0, wa_n = 0, wb_n = 0, ms_n = 0, viol = 0;
  logic [5:0] tx_addr_log [64];
  logic [0:0] tx_byte_log [64];
  logic       tx_err_log  [64];
  int         tx_cyc_log  [64];
  logic [5:0] wa_log [64];
  logic [5:0] wb_log [64];
  logic [3:0] ms_dim = 4'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_log) begin
      tx_n <= 0; wa_n <= 0; wb_n <= 0; ms_n <= 0; viol <= 0;
    end else begin
      if (tx_start) begin
        if (tx_n < 64) begin
          tx_addr_log[tx_n] <= res_addr;
          tx_byte_log[tx_n] <= res_byte;
          tx_err_log[tx_n]  <= tx_err;
          tx_cyc_log[tx_n]  <= cyc;
        end
        tx_n <= tx_n + 1;
        if (tx_busy) viol <= viol + 1;
      end
      if (we_a) begin
        if (wa_n < 64) wa_log[wa_n] <= wr_addr;
        wa_n <= wa_n + 1;
      end
      if (we_b) begin
        if (wb_n < 64) wb_log[wb_n] <= wr_addr;
        wb_n <= wb_n + 1;
      end
      if (mult_start) begin
        ms_dim <= mult_dim;
        ms_n   <= ms_n + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_done();
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
  endtask

  task automatic clear_log();
    clr_log = 1'b1;
    tick();
    clr_log = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (state !== S_IDLE && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(state), 32'(S_IDLE));
  endtask

  logic [5:0] exp_addr2 [8] = '{6'd0, 6'd0, 6'd1, 6'd1, 6'd2, 6'd2, 6'd3, 6'd3};
  logic [0:0] exp_byte2 [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    // Reset state.
    repeat (3) tick();
    check_eq("rst_state", 32'(state), 32'(S_IDLE));
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_tx_start", 32'(tx_start), 0);
    check_eq("rst_mult_dim", 32'(mult_dim), 0);
    check_eq("rst_we_a", 32'(we_a), 0);
    rst = 1'b0;
    tick();

    // 2x2 frame, fast UART.
    busy_len = 1;
    clear_log();
    send(8'h55);
    check_eq("idle_ignores_non_sync", 32'(state), 32'(S_IDLE));
    send(8'hA5);
    check_eq("f1_rx_dim", 32'(state), 32'(S_RX_DIM));
    check_eq("f1_busy", 32'(busy), 1);
    send(8'h02);
    check_eq("f1_rx_a", 32'(state), 32'(S_RX_A));
    check_eq("f1_mult_dim", 32'(mult_dim), 2);
    for (int i = 1; i <= 4; i++) send(8'(i));
    check_eq("f1_rx_b", 32'(state), 32'(S_RX_B));
    for (int i = 5; i <= 8; i++) send(8'(i));
    check_eq("f1_compute", 32'(state), 32'(S_COMPUTE));
    check_eq("f1_mult_start_hi", 32'(mult_start), 1);
    send(8'h33);
    check_eq("f1_mult_start_lo", 32'(mult_start), 0);
    check_eq("f1_rx_ignored_compute", 32'(state), 32'(S_COMPUTE));
    check_eq("f1_we_a_count", 32'(wa_n), 4);
    check_eq("f1_we_b_count", 32'(wb_n), 4);
    check_eq("f1_mult_start_count", 32'(ms_n), 1);
    check_eq("f1_mult_start_dim", 32'(ms_dim), 2);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("f1_wa_addr%0d", i), 32'(wa_log[i]), 32'(i));
      check_eq($sformatf("f1_wb_addr%0d", i), 32'(wb_log[i]), 32'(i));
    end
    pulse_done();
    wait_idle("f1_idle", 300);
    check_eq("f1_tx_count", 32'(tx_n), 8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("f1_res_addr%0d", i), 32'(tx_addr_log[i]), 32'(exp_addr2[i]));
      check_eq($sformatf("f1_res_byte%0d", i), 32'(tx_byte_log[i]), 32'(exp_byte2[i]));
      check_eq($sformatf("f1_tx_err%0d", i), 32'(tx_err_log[i]), 0);
    end
    check_eq("f1_busy_viol", 32'(viol), 0);
    check_eq("f1_busy_idle", 32'(busy), 0);

    // mult_done outside COMPUTE has no effect.
    pulse_done();
    tick();
    check_eq("done_ignored_state", 32'(state), 32'(S_IDLE));
    check_eq("done_ignored_tx", 32'(tx_n), 8);

    // Oversized dimension.
    clear_log();
    send(8'hA5);
    send(8'h09);
    check_eq("f2_tx_err_state", 32'(state), 32'(S_TX_ERR));
    check_eq("f2_err_set", 32'(err), 1);
    wait_idle("f2_idle", 100);
    check_eq("f2_tx_count", 32'(tx_n), 1);
    check_eq("f2_tx_err_flag", 32'(tx_err_log[0]), 1);
    check_eq("f2_no_we_a", 32'(wa_n), 0);
    check_eq("f2_err_sticky", 32'(err), 1);

    // 1x1 frame with a slow UART.
    busy_len = 20;
    clear_log();
    send(8'hA5);
    check_eq("f3_err_cleared", 32'(err), 0);
    send(8'h01);
    send(8'h03);
    send(8'h04);
    check_eq("f3_compute", 32'(state), 32'(S_COMPUTE));
    pulse_done();
    wait_idle("f3_idle", 500);
    check_eq("f3_tx_count", 32'(tx_n), 2);
    check_eq("f3_addr0", 32'(tx_addr_log[0]), 0);
    check_eq("f3_addr1", 32'(tx_addr_log[1]), 0);
    check_eq("f3_byte0", 32'(tx_byte_log[0]), 0);
    check_eq("f3_byte1", 32'(tx_byte_log[1]), 1);
    check_eq("f3_busy_viol", 32'(viol), 0);
    check_eq("f3_gap_over_busy", 32'((tx_cyc_log[1] - tx_cyc_log[0]) > 20), 1);

    // Reset in the middle of B, then a fresh frame.
    busy_len = 1;
    clear_log();
    send(8'hA5);
    send(8'h02);
    for (int i = 1; i <= 6; i++) send(8'(i));
    check_eq("f4_rx_b", 32'(state), 32'(S_RX_B));
    rx_valid = 1'b1;
    rx_data  = 8'h07;
    #1;
    check_eq("f4_we_b_pre", 32'(we_b), 1);
    check_eq("f4_wr_addr_pre", 32'(wr_addr), 2);
    #1;
    rst = 1'b1;
    #1;
    check_eq("f4_rst_state", 32'(state), 32'(S_IDLE));
    check_eq("f4_rst_we_b", 32'(we_b), 0);
    check_eq("f4_rst_wr_addr", 32'(wr_addr), 0);
    check_eq("f4_rst_busy", 32'(busy), 0);
    check_eq("f4_rst_mult_dim", 32'(mult_dim), 0);
    rx_valid = 1'b0;
    clear_log();
    rst = 1'b0;
    send(8'hA5);
    check_eq("f4_first_after_rst", 32'(state), 32'(S_RX_DIM));
    send(8'h01);
    send(8'h03);
    send(8'h04);
    check_eq("f4_mult_start", 32'(mult_start), 1);
    pulse_done();
    wait_idle("f4_idle", 200);
    check_eq("f4_we_a_count", 32'(wa_n), 1);
    check_eq("f4_we_b_count", 32'(wb_n), 1);
    check_eq("f4_tx_count", 32'(tx_n), 2);
    check_eq("f4_addr1", 32'(tx_addr_log[1]), 0);
    check_eq("f4_byte1", 32'(tx_byte_log[1]), 1);

`ifdef MATRIX_SEQ_TIMEOUT_EN
    // Stalled A stream trips the watchdog.
    begin
      int n;
      clear_log();
      send(8'hA5);
      send(8'h02);
      for (int i = 1; i <= 3; i++) send(8'(i));
      n = 0;
      while (state !== S_TX_ERR && n < 100) begin
        tick();
        n++;
      end
      check_eq("to_latency", 32'(n), 50);
      check_eq("to_err", 32'(err), 1);
      wait_idle("to_idle", 100);
      check_eq("to_tx_err_flag", 32'(tx_err_log[0]), 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the sequence above wedges.
  initial begin
    #2000000;
    $display("FAIL watchdog: summary not reached");
    $fatal(1, "watchdog expired");
  end

endmodule
